// File: rtl/logic_gate_pkg.sv
// Shared definitions for the pipelined multi-operand logic unit:
// function-select encodings and the op legality check.
package logic_gate_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_AND  = 3'b000;
    localparam logic [OP_W-1:0] OP_OR   = 3'b001;
    localparam logic [OP_W-1:0] OP_XOR  = 3'b010;
    localparam logic [OP_W-1:0] OP_NAND = 3'b011;
    localparam logic [OP_W-1:0] OP_NOR  = 3'b100;
    localparam logic [OP_W-1:0] OP_XNOR = 3'b101;

    // Codes above OP_XNOR are reserved and flagged as errors.
    function automatic logic is_valid_op(input logic [OP_W-1:0] op);
        return (op <= OP_XNOR);
    endfunction

endpackage

// File: rtl/gate_reduce.sv
// Combinational NUM_IN-way bitwise reduction. Inverting functions
// invert the full-width reduction, not a chain of two-input gates.
module gate_reduce
    import logic_gate_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int NUM_IN = 4
) (
    input  logic [OP_W-1:0]         op,
    input  logic [NUM_IN*WIDTH-1:0] operands,
    output logic [WIDTH-1:0]        result,
    output logic                    err
);

    logic [WIDTH-1:0] and_r;
    logic [WIDTH-1:0] or_r;
    logic [WIDTH-1:0] xor_r;

    // Fold all operands into the three base reductions.
    always_comb begin
        and_r = '1;
        or_r  = '0;
        xor_r = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            and_r = and_r & operands[k*WIDTH +: WIDTH];
            or_r  = or_r  | operands[k*WIDTH +: WIDTH];
            xor_r = xor_r ^ operands[k*WIDTH +: WIDTH];
        end
    end

    // Select the requested function; reserved codes give zero plus error.
    always_comb begin
        result = '0;
        err    = !is_valid_op(op);
        case (op)
            OP_AND:  result = and_r;
            OP_OR:   result = or_r;
            OP_XOR:  result = xor_r;
            OP_NAND: result = ~and_r;
            OP_NOR:  result = ~or_r;
            OP_XNOR: result = ~xor_r;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/logic_gate_pipe.sv
// Two-stage valid/ready pipeline around gate_reduce. Stage 1 holds the
// raw operand set, stage 2 holds the reduced result and its flags.
// Each stage advances only when the stage ahead of it can take data,
// so up to two transactions are buffered under output back-pressure.
module logic_gate_pipe
    import logic_gate_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int NUM_IN = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [OP_W-1:0]         op,
    input  logic [NUM_IN*WIDTH-1:0] operands,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        result,
    output logic                    out_zero,
    output logic                    out_err
);

    logic                    s1_valid_q,    s1_valid_d;
    logic [OP_W-1:0]         s1_op_q,       s1_op_d;
    logic [NUM_IN*WIDTH-1:0] s1_operands_q, s1_operands_d;

    logic                    s2_valid_q,    s2_valid_d;
    logic [WIDTH-1:0]        result_q,      result_d;
    logic                    zero_q,        zero_d;
    logic                    err_q,         err_d;

    logic                    s1_load;
    logic                    s2_load;
    logic [WIDTH-1:0]        red_result;
    logic                    red_err;

    gate_reduce #(
        .WIDTH  (WIDTH),
        .NUM_IN (NUM_IN)
    ) u_reduce (
        .op       (s1_op_q),
        .operands (s1_operands_q),
        .result   (red_result),
        .err      (red_err)
    );

    // Stage advance conditions; in_ready depends only on pipeline state and out_ready.
    always_comb begin
        s2_load = !s2_valid_q || out_ready;
        s1_load = !s1_valid_q || s2_load;
    end

    assign in_ready  = s1_load;
    assign out_valid = s2_valid_q;
    assign result    = result_q;
    assign out_zero  = zero_q;
    assign out_err   = err_q;

    // Stage 1 next state: capture the operand set on an input transfer.
    always_comb begin
        s1_valid_d    = s1_valid_q;
        s1_op_d       = s1_op_q;
        s1_operands_d = s1_operands_q;
        if (s1_load) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_op_d       = op;
                s1_operands_d = operands;
            end
        end
    end

    // Stage 2 next state: take the reduced value whenever stage 1 moves forward;
    // payload is left untouched otherwise so a stalled beat stays stable.
    always_comb begin
        s2_valid_d = s2_valid_q;
        result_d   = result_q;
        zero_d     = zero_q;
        err_d      = err_q;
        if (s2_load) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                result_d = red_result;
                zero_d   = (red_result == '0);
                err_d    = red_err;
            end
        end
    end

    // Pipeline registers; reset discards anything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q    <= 1'b0;
            s1_op_q       <= '0;
            s1_operands_q <= '0;
            s2_valid_q    <= 1'b0;
            result_q      <= '0;
            zero_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            s1_valid_q    <= s1_valid_d;
            s1_op_q       <= s1_op_d;
            s1_operands_q <= s1_operands_d;
            s2_valid_q    <= s2_valid_d;
            result_q      <= result_d;
            zero_q        <= zero_d;
            err_q         <= err_d;
        end
    end

endmodule

// File: doc/logic_gate_pipe.md
Name: logic_gate_pipe

Overview:
Parametrised, pipelined successor to the two-input AND gate. Applies one of six bitwise logic functions across NUM_IN operands of WIDTH bits, selected per transaction. Uses a two-stage registered pipeline with valid/ready handshakes on input and output. Serves as the general-purpose logic unit for the combinational-circuit library and its datapath benches.

Parameters:
WIDTH, 8, bit width of each operand and of the result (≥1)
NUM_IN, 4, number of operands reduced per transaction (≥2)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
in_valid  input  1  an operand set is presented
in_ready  output  1  block can accept an operand set this cycle
op  input  3  function select, sampled with in_valid
operands  input  NUM_IN*WIDTH  packed operands; operand k occupies bits [k*WIDTH +: WIDTH]
out_valid  output  1  result is presented
out_ready  input  1  downstream accepts the result
result  output  WIDTH  bitwise reduction result
out_zero  output  1  result is all zeros
out_err  output  1  op was an unsupported code

Behaviour:
- Reset (rst=1 at a clk edge): s1_valid=0, s2_valid=0, out_valid=0, result=0, out_zero=0, out_err=0. in_ready is 1 in the first cycle after reset. Reset has priority over every handshake; any transaction in flight is discarded, not completed.
- Op codes: 000 AND, 001 OR, 010 XOR, 011 NAND, 100 NOR, 101 XNOR. NAND/NOR/XNOR are the bitwise inversions of the NUM_IN-wide AND/OR/XOR reduction, not chained two-input gates. Codes 110/111 produce result=0 and out_err=1.
- Stage 1 registers op and operands when in_valid && in_ready. Stage 2 registers result, out_zero and out_err, all computed from the stage-1 contents.
- Handshake: a transfer occurs on a cycle where valid && ready. Per-stage advance rules:
  - s2 loads when !s2_valid || out_ready.
  - s1 loads when !s1_valid || s2 loads.
  - in_ready = !s1_valid || s2 loads. This is combinational; there is no combinational path from in_valid to in_ready.
- Latency: 2 cycles from input transfer to out_valid with no stall. Throughput is 1 transaction per cycle when out_ready is held at 1.
- Stall: while out_valid && !out_ready, result, out_zero and out_err hold stable. At most 2 transactions are buffered. in_ready drops only when both stages are full and out_ready=0.
- Simultaneous events:
  - Output consumed and input accepted in the same cycle: both transfers occur and no bubble is inserted.
  - s1 empty while s2 drains: s2_valid clears after the transfer.
- Once out_valid is asserted, it stays asserted until a transfer occurs.
- No transaction is dropped, duplicated or reordered.
- out_zero = (result == 0). It is also 1 on an error beat.

Decomposition:
- Package logic_gate_pkg:
  - op localparams OP_AND..OP_XNOR (3-bit)
  - OP_W=3
  - function is_valid_op
- Sub-module gate_reduce:
  - purely combinational
  - inputs op and operands; outputs result and err
  - parametrised by WIDTH and NUM_IN
  - instantiated between stage 1 and stage 2
- The pipeline control stays in logic_gate_pipe.

Test Plan:
- WIDTH=8, NUM_IN=4, out_ready=1. Operands F0,FF,3C,F1 with op AND → result=30, out_zero=0, out_err=0, out_valid exactly 2 cycles after the input transfer.
- Back-to-back ops OR/XOR/NOR on operands 01,02,04,08, out_ready=1 → results 0F, 0F, F0 on 3 consecutive cycles, in_ready constantly 1.
- NAND on FF,FF,FF,FF → result=00, out_zero=1. Op 110 → result=00, out_err=1.
- out_ready=0 while 3 inputs are offered → first 2 accepted, in_ready=0 on the 3rd. Result holds for 5 cycles. Then out_ready=1 → 3 results in order with no loss.
- rst asserted with both stages valid → next cycle out_valid=0, result=0, in_ready=1. No stale result appears after release.
- Randomised valid/ready toggling over 1000 transactions against a reference model → results match in order; no handshake violation (out_valid never drops and result never changes while stalled).
